// File: rtl/cumsum_reverse_row_reverser_if.sv
// -----------------------------------------------------------------------------
// cumsum_reverse_row_reverser_if
// Bundles the two ready/valid streams of the row reverser.
//   Upstream   : valid_in, ready_out, input_data  (natural-order elements)
//   Downstream : valid_out, ready_in, output_data, last_out (reversed row)
// Modports:
//   slave  - the reverser itself (consumes upstream, produces downstream)
//   master - the environment around it (produces upstream, consumes downstream)
// -----------------------------------------------------------------------------
interface cumsum_reverse_row_reverser_if #(
   parameter int DATA_W = 32
);
   logic              valid_in;
   logic              ready_out;
   logic [DATA_W-1:0] input_data;
   logic              valid_out;
   logic              ready_in;
   logic [DATA_W-1:0] output_data;
   logic              last_out;

   modport slave (
      input  valid_in,
      input  input_data,
      input  ready_in,
      output ready_out,
      output valid_out,
      output output_data,
      output last_out
   );

   modport master (
      output valid_in,
      output input_data,
      output ready_in,
      input  ready_out,
      input  valid_out,
      input  output_data,
      input  last_out
   );
endinterface

// File: rtl/cumsum_reverse_row_reverser.sv
// -----------------------------------------------------------------------------
// cumsum_reverse_row_reverser
// Collects one row of ROW_LEN elements in natural order, then replays it in
// reverse order so the downstream reverse-cumsum stage can use a plain forward
// running sum. A single row buffer alternates between FILL and DRAIN, so fill
// and drain never overlap.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - slave side of cumsum_reverse_row_reverser_if
//            (valid_in/ready_out/input_data upstream,
//             valid_out/ready_in/output_data/last_out downstream)
// -----------------------------------------------------------------------------
module cumsum_reverse_row_reverser #(
   parameter int DATA_W  = 32,
   parameter int ROW_LEN = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   cumsum_reverse_row_reverser_if.slave  bus
);

   localparam int AW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;

   localparam logic [0:0] S_FILL  = 1'b0;
   localparam logic [0:0] S_DRAIN = 1'b1;

   localparam logic [AW-1:0] LAST_WR  = AW'(ROW_LEN - 1);
   // The last element is bypassed straight to the output, so the memory
   // replay starts one slot below it. Unused when ROW_LEN is 1.
   localparam logic [AW-1:0] RD_START = AW'(ROW_LEN - 2);

   logic [0:0]        r_state;
   logic [AW-1:0]     r_wr_cnt;
   logic [AW-1:0]     r_rd_idx;
   logic              r_ready_out;
   logic              r_valid_out;
   logic              r_last_out;
   logic [DATA_W-1:0] r_output_data;
   logic [DATA_W-1:0] r_mem [ROW_LEN];

   logic w_in_fire;
   logic w_out_fire;

   assign w_in_fire  = bus.valid_in & r_ready_out;
   assign w_out_fire = r_valid_out & bus.ready_in;

   assign bus.ready_out   = r_ready_out;
   assign bus.valid_out   = r_valid_out;
   assign bus.last_out    = r_last_out;
   assign bus.output_data = r_output_data;

   // Row buffer write port; contents are intentionally left unreset.
   always_ff @(posedge clk) begin
      if (w_in_fire) begin
         r_mem[r_wr_cnt] <= bus.input_data;
      end
   end

   // Fill/drain sequencer and registered output stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_FILL;
         r_wr_cnt      <= {AW{1'b0}};
         r_rd_idx      <= {AW{1'b0}};
         r_ready_out   <= 1'b1;
         r_valid_out   <= 1'b0;
         r_last_out    <= 1'b0;
         r_output_data <= {DATA_W{1'b0}};
      end else begin
         case (r_state)
            S_FILL: begin
               if (w_in_fire) begin
                  if (r_wr_cnt == LAST_WR) begin
                     // Final element goes straight out, saving a cycle.
                     r_state       <= S_DRAIN;
                     r_ready_out   <= 1'b0;
                     r_output_data <= bus.input_data;
                     r_valid_out   <= 1'b1;
                     r_last_out    <= (ROW_LEN == 1) ? 1'b1 : 1'b0;
                     r_rd_idx      <= RD_START;
                     r_wr_cnt      <= {AW{1'b0}};
                  end else begin
                     r_wr_cnt <= r_wr_cnt + AW'(1);
                  end
               end
            end
            S_DRAIN: begin
               if (w_out_fire) begin
                  if (r_last_out) begin
                     r_valid_out <= 1'b0;
                     r_last_out  <= 1'b0;
                     r_state     <= S_FILL;
                     r_ready_out <= 1'b1;
                  end else begin
                     r_output_data <= r_mem[r_rd_idx];
                     r_last_out    <= (r_rd_idx == {AW{1'b0}});
                     r_rd_idx      <= r_rd_idx - AW'(1);
                  end
               end
            end
            default: begin
               r_state     <= S_FILL;
               r_ready_out <= 1'b1;
               r_valid_out <= 1'b0;
               r_last_out  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cumsum_reverse_row_reverser.sv
// -----------------------------------------------------------------------------
// tb_cumsum_reverse_row_reverser
// Randomized bench for the row reverser (ROW_LEN=4) plus a small directed
// section on a ROW_LEN=1 instance. Accepted inputs are grouped into rows in a
// queue; each completed row is appended reversed to an expected-output queue.
// -----------------------------------------------------------------------------
module tb_cumsum_reverse_row_reverser;

   localparam int DW = 32;
   localparam int RL = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   cumsum_reverse_row_reverser_if #(.DATA_W(DW)) bus  ();
   cumsum_reverse_row_reverser_if #(.DATA_W(DW)) bus1 ();

   cumsum_reverse_row_reverser #(.DATA_W(DW), .ROW_LEN(RL)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   cumsum_reverse_row_reverser #(.DATA_W(DW), .ROW_LEN(1)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] in_q[$];
   logic [DW-1:0] row_q[$];

   int n_checks   = 0;
   int n_errors   = 0;
   int bubble_pct = 0;
   int stall_pct  = 0;
   int out_cnt    = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic drive();
      bus.valid_in   = (in_q.size() != 0) && (int'($urandom_range(99)) >= bubble_pct);
      bus.input_data = (in_q.size() != 0) ? in_q[0] : $urandom();
      bus.ready_in   = (int'($urandom_range(99)) >= stall_pct);
   endtask

   // One clock: check outputs against the model at negedge, advance the model
   // by the handshakes that will happen at the next posedge, then redrive.
   task automatic tick();
      bit busy;
      bit in_fire;
      bit out_fire;
      @(negedge clk);
      busy = (exp_q.size() != 0);
      check_eq("ready_out", bus.ready_out, !busy);
      check_eq("valid_out", bus.valid_out, busy);
      if (busy) begin
         check_eq("output_data", bus.output_data, exp_q[0].d);
         check_eq("last_out", bus.last_out, exp_q[0].l);
      end
      out_fire = busy && bus.ready_in;
      in_fire  = !busy && bus.valid_in;
      if (out_fire) begin
         void'(exp_q.pop_front());
         out_cnt++;
      end
      if (in_fire) begin
         row_q.push_back(in_q.pop_front());
         if (row_q.size() == RL) begin
            for (int i = RL - 1; i >= 0; i--) begin
               exp_q.push_back('{d: row_q[i], l: (i == 0)});
            end
            row_q.delete();
         end
      end
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic run_idle(input int budget);
      int c;
      c = 0;
      while ((in_q.size() != 0 || row_q.size() != 0 || exp_q.size() != 0) && c < budget) begin
         tick();
         c++;
      end
      check_eq("run_complete", (c < budget), 1'b1);
   endtask

   initial begin
      int c;
      bus.valid_in    = 1'b0;
      bus.input_data  = '0;
      bus.ready_in    = 1'b1;
      bus1.valid_in   = 1'b0;
      bus1.input_data = '0;
      bus1.ready_in   = 1'b1;

      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_eq("rst_ready_out", bus.ready_out, 1'b1);
      check_eq("rst_valid_out", bus.valid_out, 1'b0);
      check_eq("rst_last_out", bus.last_out, 1'b0);
      check_eq("rst_output_data", bus.output_data, 64'd0);
      @(posedge clk);
      #1;

      // Simple row, no bubbles or stalls.
      bubble_pct = 0; stall_pct = 0;
      for (int i = 1; i <= 4; i++) in_q.push_back(DW'(i));
      drive();
      run_idle(100);

      // Downstream stalls.
      bubble_pct = 0; stall_pct = 50;
      for (int i = 1; i <= 4; i++) in_q.push_back(DW'(i * 10));
      drive();
      run_idle(200);

      // Back-to-back rows with valid_in held high.
      bubble_pct = 0; stall_pct = 0;
      for (int i = 1; i <= 8; i++) in_q.push_back(DW'(i));
      drive();
      run_idle(200);

      // Full-width patterns with input bubbles.
      bubble_pct = 50; stall_pct = 0;
      in_q.push_back(32'hDEADBEEF);
      in_q.push_back(32'h0000_0000);
      in_q.push_back(32'hFFFF_FFFF);
      in_q.push_back(32'h0000_0007);
      drive();
      run_idle(300);

      // Random rows with both bubbles and stalls.
      bubble_pct = 30; stall_pct = 40;
      for (int i = 0; i < 20 * RL; i++) in_q.push_back($urandom());
      drive();
      run_idle(3000);

      // Reset in the middle of a drain.
      bubble_pct = 0; stall_pct = 0;
      out_cnt = 0;
      for (int i = 1; i <= 4; i++) in_q.push_back(DW'(i));
      drive();
      c = 0;
      while (out_cnt < 2 && c < 100) begin
         tick();
         c++;
      end
      check_eq("mid_drain_reached", (out_cnt >= 2), 1'b1);
      #1 rst_n = 1'b0;
      #1;
      check_eq("arst_valid_out", bus.valid_out, 1'b0);
      check_eq("arst_last_out", bus.last_out, 1'b0);
      check_eq("arst_output_data", bus.output_data, 64'd0);
      check_eq("arst_ready_out", bus.ready_out, 1'b1);
      exp_q.delete();
      row_q.delete();
      in_q.delete();
      bus.valid_in = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 5; i <= 8; i++) in_q.push_back(DW'(i));
      drive();
      run_idle(100);

      // ROW_LEN=1 instance: 9 then 3, each alone as a row.
      bus1.valid_in   = 1'b1;
      bus1.input_data = 32'd9;
      @(negedge clk);
      check_eq("r1_ready_idle", bus1.ready_out, 1'b1);
      @(posedge clk);
      #1 bus1.input_data = 32'd3;
      @(negedge clk);
      check_eq("r1_valid_9", bus1.valid_out, 1'b1);
      check_eq("r1_data_9", bus1.output_data, 64'd9);
      check_eq("r1_last_9", bus1.last_out, 1'b1);
      check_eq("r1_busy_9", bus1.ready_out, 1'b0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check_eq("r1_gap_valid", bus1.valid_out, 1'b0);
      check_eq("r1_gap_ready", bus1.ready_out, 1'b1);
      @(posedge clk);
      #1 bus1.valid_in = 1'b0;
      @(negedge clk);
      check_eq("r1_valid_3", bus1.valid_out, 1'b1);
      check_eq("r1_data_3", bus1.output_data, 64'd3);
      check_eq("r1_last_3", bus1.last_out, 1'b1);
      check_eq("r1_busy_3", bus1.ready_out, 1'b0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check_eq("r1_end_valid", bus1.valid_out, 1'b0);
      check_eq("r1_end_ready", bus1.ready_out, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
